// File: rtl/bus_pkg.sv
// Shared bus definitions for the accumulator controller and its bus target.
// Holds the bus widths, the register address map and a decode helper that maps
// a word address onto the register it selects.
package bus_pkg;

  localparam int unsigned BUS_DW = 32;
  localparam int unsigned BUS_AW = 8;

  localparam logic [BUS_AW-1:0] ADDR_TIMER      = 8'h10;
  localparam logic [BUS_AW-1:0] ADDR_TCTRL      = 8'h11;
  localparam logic [BUS_AW-1:0] ADDR_SCRATCH    = 8'h12;
  localparam logic [BUS_AW-1:0] ADDR_OUTPORT    = 8'h13;
  localparam logic [BUS_AW-1:0] ADDR_FIFO_DATA  = 8'h14;
  localparam logic [BUS_AW-1:0] ADDR_FIFO_COUNT = 8'h15;

  typedef enum logic [2:0] {
    RegNone,
    RegRam,
    RegTimer,
    RegTctrl,
    RegScratch,
    RegOutport,
    RegFifoData,
    RegFifoCount
  } reg_sel_e;

  // RAM occupies 0 .. ram_words-1; everything unmapped decodes to RegNone.
  function automatic reg_sel_e decode_addr(input logic [BUS_AW-1:0] addr,
                                           input int unsigned ram_words);
    reg_sel_e sel;
    sel = RegNone;
    if (32'(addr) < ram_words) begin
      sel = RegRam;
    end else begin
      case (addr)
        ADDR_TIMER:      sel = RegTimer;
        ADDR_TCTRL:      sel = RegTctrl;
        ADDR_SCRATCH:    sel = RegScratch;
        ADDR_OUTPORT:    sel = RegOutport;
        ADDR_FIFO_DATA:  sel = RegFifoData;
        ADDR_FIFO_COUNT: sel = RegFifoCount;
        default:         sel = RegNone;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Synchronous FIFO used as the responder's input queue.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset (clears pointers/count)
//   push_i, wdata_i - enqueue wdata_i (ignored while full)
//   pop_i, rdata_o  - rdata_o shows the head combinationally; pop_i dequeues it
//                     (ignored while empty)
//   count_o         - number of stored entries, 0..DEPTH
//   full_o, empty_o - status from the registered count
module bus_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = BUS_DW,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    // DEPTH is a power of two, so the pointers wrap on their own.
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped bus target for the accumulator controller.
// Holds a data RAM, a free-running timer with enable, a scratch register, an
// output port latch with a one-cycle strobe and an input FIFO fed by a producer.
// Ports:
//   CLK, RST_N       - clock, asynchronous active-low reset
//   busAddr          - word address
//   busRead          - read strobe; busRData updates on the sampling edge
//   busWrite         - write strobe with busWData
//   busRData         - registered read data, held between reads
//   inValid, inData  - producer offer; accepted when inReady is high
//   inReady          - FIFO not full (from registered count only)
//   outValid         - one-cycle pulse after an OUTPORT write
//   outData          - output port latch
module bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RAM_WORDS  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BUS_AW-1:0] busAddr,
  input  logic              busRead,
  input  logic              busWrite,
  input  logic [BUS_DW-1:0] busWData,
  output logic [BUS_DW-1:0] busRData,
  input  logic              inValid,
  input  logic [BUS_DW-1:0] inData,
  output logic              inReady,
  output logic              outValid,
  output logic [BUS_DW-1:0] outData
);

  localparam int unsigned CntW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned RamIdxW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  reg_sel_e          sel;
  logic [RamIdxW-1:0] ram_idx;
  logic              ram_we;

  logic [BUS_DW-1:0] ram_q [RAM_WORDS];
  logic [BUS_DW-1:0] rdata_q, rdata_d;
  logic [BUS_DW-1:0] timer_q, timer_d;
  logic              tctrl_q, tctrl_d;
  logic [BUS_DW-1:0] scratch_q, scratch_d;
  logic [BUS_DW-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [BUS_DW-1:0] rd_mux;

  logic              fifo_push, fifo_pop;
  logic [BUS_DW-1:0] fifo_head;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BUS_DW)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .push_i  (fifo_push),
    .wdata_i (inData),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign busRData = rdata_q;
  assign outData  = out_data_q;
  assign outValid = out_valid_q;
  assign inReady  = ~fifo_full;

  always_comb begin
    sel     = decode_addr(busAddr, RAM_WORDS);
    ram_idx = busAddr[RamIdxW-1:0];
    ram_we  = busWrite && (sel == RegRam);

    // A read of FIFO_DATA pops even when a write happens in the same cycle.
    fifo_pop  = busRead && (sel == RegFifoData) && !fifo_empty;
    fifo_push = inValid && !fifo_full;

    // All sources are pre-write state, so read+write returns the old value.
    rd_mux = '0;
    case (sel)
      RegRam:       rd_mux = ram_q[ram_idx];
      RegTimer:     rd_mux = timer_q;
      RegTctrl:     rd_mux = BUS_DW'(tctrl_q);
      RegScratch:   rd_mux = scratch_q;
      RegOutport:   rd_mux = out_data_q;
      RegFifoData:  rd_mux = fifo_empty ? '0 : fifo_head;
      RegFifoCount: rd_mux = BUS_DW'(fifo_count);
      default:      rd_mux = '0;
    endcase
    rdata_d = busRead ? rd_mux : rdata_q;

    // A bus load of the timer overrides that cycle's increment.
    timer_d = tctrl_q ? timer_q + 1'b1 : timer_q;
    if (busWrite && (sel == RegTimer)) begin
      timer_d = busWData;
    end

    tctrl_d = tctrl_q;
    if (busWrite && (sel == RegTctrl)) begin
      tctrl_d = busWData[0];
    end

    scratch_d = scratch_q;
    if (busWrite && (sel == RegScratch)) begin
      scratch_d = busWData;
    end

    out_valid_d = busWrite && (sel == RegOutport);
    out_data_d  = out_valid_d ? busWData : out_data_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdata_q     <= '0;
      timer_q     <= '0;
      tctrl_q     <= 1'b0;
      scratch_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      rdata_q     <= rdata_d;
      timer_q     <= timer_d;
      tctrl_q     <= tctrl_d;
      scratch_q   <= scratch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // RAM keeps its contents across reset.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram_q[ram_idx] <= busWData;
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  busAddr;
  logic        busRead;
  logic        busWrite;
  logic [31:0] busWData;
  logic [31:0] busRData;
  logic        inValid;
  logic [31:0] inData;
  logic        inReady;
  logic        outValid;
  logic [31:0] outData;

  int n_checks = 0;
  int n_errors = 0;

  bus_responder #(
    .FIFO_DEPTH (4),
    .RAM_WORDS  (16)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .busAddr  (busAddr),
    .busRead  (busRead),
    .busWrite (busWrite),
    .busWData (busWData),
    .busRData (busRData),
    .inValid  (inValid),
    .inData   (inData),
    .inReady  (inReady),
    .outValid (outValid),
    .outData  (outData)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic        iv;
    logic [31:0] id;
    logic [31:0] e_rd;
    logic        e_ov;
    logic [31:0] e_od;
    logic        e_rdy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [7:0] addr, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic iv, input logic [31:0] id,
                              input logic [31:0] e_rd, input logic e_ov,
                              input logic [31:0] e_od, input logic e_rdy);
    vec_t v;
    v.addr = addr; v.rd = rd; v.wr = wr; v.wd = wd; v.iv = iv; v.id = id;
    v.e_rd = e_rd; v.e_ov = e_ov; v.e_od = e_od; v.e_rdy = e_rdy;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, let the edge consume it, sample 1 time unit later.
  task automatic cyc(input logic [7:0] a, input logic r, input logic w, input logic [31:0] wd,
                     input logic iv, input logic [31:0] id);
    busAddr = a; busRead = r; busWrite = w; busWData = wd; inValid = iv; inData = id;
    @(posedge CLK);
    #1;
    busRead = 1'b0; busWrite = 1'b0; inValid = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    cyc(a, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk(name, busRData, exp);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] wd);
    cyc(a, 1'b0, 1'b1, wd, 1'b0, 32'h0);
  endtask

  initial begin
    RST_N = 1'b0;
    busAddr = '0; busRead = 1'b0; busWrite = 1'b0; busWData = '0;
    inValid = 1'b0; inData = '0;

    // addr rd wr wdata iv idata | rdata ov outData ready
    add(8'h05, 0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h0,  1);
    add(8'h05, 1, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0,  1);
    add(8'h40, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,  1);
    add(8'h12, 0, 1, 32'h1,        0, 0, 32'h0,        0, 32'h0,  1);
    add(8'h12, 1, 0, 32'h0,        0, 0, 32'h1,        0, 32'h0,  1);
    add(8'h12, 1, 1, 32'h2,        0, 0, 32'h1,        0, 32'h0,  1);
    add(8'h12, 1, 0, 32'h0,        0, 0, 32'h2,        0, 32'h0,  1);
    add(8'h13, 0, 1, 32'h2A,       0, 0, 32'h2,        1, 32'h2A, 1);
    add(8'h00, 0, 0, 32'h0,        0, 0, 32'h2,        0, 32'h2A, 1);
    add(8'h13, 1, 0, 32'h0,        0, 0, 32'h2A,       0, 32'h2A, 1);
    add(8'h13, 0, 1, 32'h55,       0, 0, 32'h2A,       1, 32'h55, 1);
    add(8'h13, 0, 1, 32'h66,       0, 0, 32'h2A,       1, 32'h66, 1);
    add(8'h00, 0, 0, 32'h0,        0, 0, 32'h2A,       0, 32'h66, 1);
    add(8'h15, 0, 1, 32'h1234,     0, 0, 32'h2A,       0, 32'h66, 1);
    add(8'h15, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h66, 1);
    add(8'h20, 0, 1, 32'hFFFF,     0, 0, 32'h0,        0, 32'h66, 1);
    add(8'h20, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h66, 1);
    add(8'h10, 0, 1, 32'h100,      0, 0, 32'h0,        0, 32'h66, 1);
    add(8'h10, 1, 0, 32'h0,        0, 0, 32'h100,      0, 32'h66, 1);
    add(8'h11, 0, 1, 32'hFFFFFFFE, 0, 0, 32'h100,      0, 32'h66, 1);
    add(8'h11, 1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h66, 1);
    add(8'h10, 1, 0, 32'h0,        0, 0, 32'h100,      0, 32'h66, 1);
    add(8'h0F, 0, 1, 32'hA5A5A5A5, 0, 0, 32'h100,      0, 32'h66, 1);
    add(8'h0F, 1, 0, 32'h0,        0, 0, 32'hA5A5A5A5, 0, 32'h66, 1);
    add(8'h00, 0, 1, 32'h01234567, 0, 0, 32'hA5A5A5A5, 0, 32'h66, 1);
    add(8'h00, 1, 0, 32'h0,        0, 0, 32'h01234567, 0, 32'h66, 1);
    add(8'h05, 1, 0, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h66, 1);
    // FIFO: fill, drop fifth, pop with blocked push, push+pop at count 2
    add(8'h00, 0, 0, 32'h0,        1, 32'h11, 32'hDEADBEEF, 0, 32'h66, 1);
    add(8'h00, 0, 0, 32'h0,        1, 32'h22, 32'hDEADBEEF, 0, 32'h66, 1);
    add(8'h00, 0, 0, 32'h0,        1, 32'h33, 32'hDEADBEEF, 0, 32'h66, 1);
    add(8'h00, 0, 0, 32'h0,        1, 32'h44, 32'hDEADBEEF, 0, 32'h66, 0);
    add(8'h00, 0, 0, 32'h0,        1, 32'h99, 32'hDEADBEEF, 0, 32'h66, 0);
    add(8'h15, 1, 0, 32'h0,        0, 0,      32'h4,        0, 32'h66, 0);
    add(8'h14, 1, 0, 32'h0,        1, 32'h77, 32'h11,       0, 32'h66, 1);
    add(8'h14, 1, 0, 32'h0,        0, 0,      32'h22,       0, 32'h66, 1);
    add(8'h14, 1, 0, 32'h0,        1, 32'h55, 32'h33,       0, 32'h66, 1);
    add(8'h15, 1, 0, 32'h0,        0, 0,      32'h2,        0, 32'h66, 1);
    add(8'h14, 1, 1, 32'hDEAD,     0, 0,      32'h44,       0, 32'h66, 1);
    add(8'h14, 1, 0, 32'h0,        0, 0,      32'h55,       0, 32'h66, 1);
    add(8'h14, 1, 0, 32'h0,        0, 0,      32'h0,        0, 32'h66, 1);
    add(8'h15, 1, 0, 32'h0,        0, 0,      32'h0,        0, 32'h66, 1);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("reset rdata", busRData, 32'h0);
    chk("reset outValid", 32'(outValid), 32'h0);
    chk("reset outData", outData, 32'h0);
    chk("reset inReady", 32'(inReady), 32'h1);
    RST_N = 1'b1;

    foreach (vq[i]) begin
      cyc(vq[i].addr, vq[i].rd, vq[i].wr, vq[i].wd, vq[i].iv, vq[i].id);
      chk($sformatf("vec%0d rdata", i), busRData, vq[i].e_rd);
      chk($sformatf("vec%0d outValid", i), 32'(outValid), 32'(vq[i].e_ov));
      chk($sformatf("vec%0d outData", i), outData, vq[i].e_od);
      chk($sformatf("vec%0d inReady", i), 32'(inReady), 32'(vq[i].e_rdy));
    end

    // Timer wrap, load-over-increment, read+write, disable
    wr(8'h10, 32'hFFFFFFFE);
    wr(8'h11, 32'h1);
    cyc(8'h00, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    rd_chk("timer pre-wrap", 8'h10, 32'hFFFFFFFF);
    rd_chk("timer wrap", 8'h10, 32'h0);
    rd_chk("timer post-wrap", 8'h10, 32'h1);
    wr(8'h10, 32'h1000);
    rd_chk("timer load wins", 8'h10, 32'h1000);
    rd_chk("tctrl enabled", 8'h11, 32'h1);
    cyc(8'h10, 1'b1, 1'b1, 32'h5, 1'b0, 32'h0);
    chk("timer rw old", busRData, 32'h1002);
    rd_chk("timer rw new", 8'h10, 32'h5);
    wr(8'h11, 32'h0);
    rd_chk("timer stopped a", 8'h10, 32'h7);
    rd_chk("timer stopped b", 8'h10, 32'h7);

    // Asynchronous reset mid-traffic
    wr(8'h11, 32'h1);
    for (int k = 0; k < 4; k++) cyc(8'h00, 1'b0, 1'b0, 32'h0, 1'b1, 32'(k + 1));
    chk("pre-reset inReady", 32'(inReady), 32'h0);
    rd_chk("pre-reset scratch", 8'h12, 32'h2);
    wr(8'h13, 32'hABCD);
    chk("pre-reset outValid", 32'(outValid), 32'h1);
    #2 RST_N = 1'b0;
    #1;
    chk("async rst rdata", busRData, 32'h0);
    chk("async rst outValid", 32'(outValid), 32'h0);
    chk("async rst outData", outData, 32'h0);
    chk("async rst inReady", 32'(inReady), 32'h1);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    rd_chk("post-rst timer", 8'h10, 32'h0);
    rd_chk("post-rst tctrl", 8'h11, 32'h0);
    rd_chk("post-rst count", 8'h15, 32'h0);
    rd_chk("post-rst fifo pop", 8'h14, 32'h0);
    rd_chk("post-rst scratch", 8'h12, 32'h0);
    rd_chk("post-rst ram kept", 8'h05, 32'hDEADBEEF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
